// File: rtl/mcore_imem_net_arbiter_pkg.sv
// Shared message types and source-ID helpers for the four-core imem network.
package mcore_imem_net_arbiter_pkg;

  localparam int c_src_id_msb = 7;
  localparam int c_src_id_lsb = 6;
  localparam int c_src_id_w   = c_src_id_msb - c_src_id_lsb + 1;

  // 175-bit memory request
  typedef struct packed {
    logic [2:0]   msg_type;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  // 145-bit memory response
  typedef struct packed {
    logic [2:0]   msg_type;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

  function automatic logic [7:0] set_src_id(input logic [7:0] opaque,
                                            input logic [c_src_id_w-1:0] id);
    logic [7:0] r;
    r = opaque;
    r[c_src_id_msb:c_src_id_lsb] = id;
    return r;
  endfunction

endpackage

// File: rtl/mcore_imem_net_arbiter_if.sv
// Core-side and memory-side handshake bundle of the imem network arbiter.
interface mcore_imem_net_arbiter_if
  import mcore_imem_net_arbiter_pkg::*;
  #(parameter int p_num_ports = 4);

  mem_req_16B_t  [p_num_ports-1:0] in_req_msg;
  logic          [p_num_ports-1:0] in_req_val;
  logic          [p_num_ports-1:0] in_req_rdy;
  mem_resp_16B_t [p_num_ports-1:0] in_resp_msg;
  logic          [p_num_ports-1:0] in_resp_val;
  logic          [p_num_ports-1:0] in_resp_rdy;
  mem_req_16B_t                    mem_req_msg;
  logic                            mem_req_val;
  logic                            mem_req_rdy;
  mem_resp_16B_t                   mem_resp_msg;
  logic                            mem_resp_val;
  logic                            mem_resp_rdy;

  modport slave (
    input  in_req_msg, in_req_val, in_resp_rdy, mem_req_rdy, mem_resp_msg, mem_resp_val,
    output in_req_rdy, in_resp_msg, in_resp_val, mem_req_msg, mem_req_val, mem_resp_rdy
  );

  modport master (
    output in_req_msg, in_req_val, in_resp_rdy, mem_req_rdy, mem_resp_msg, mem_resp_val,
    input  in_req_rdy, in_resp_msg, in_resp_val, mem_req_msg, mem_req_val, mem_resp_rdy
  );

endinterface

// File: rtl/mcore_imem_net_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the winner on en.
module mcore_rr_arbiter #(
  parameter int p_n = 4,
  parameter int c_w = $clog2(p_n)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [p_n-1:0] req,
  input  logic           en,
  output logic [p_n-1:0] grant,
  output logic [c_w-1:0] winner
);

  logic [c_w-1:0] ptr;
  logic [c_w-1:0] idx;

  // Walk from the farthest offset back to the pointer so the closest requester wins;
  // the index add wraps because p_n is a power of two.
  always_comb begin
    idx    = ptr;
    winner = ptr;
    for (int k = p_n - 1; k >= 0; k--) begin
      idx = ptr + c_w'(k);
      if (req[idx]) winner = idx;
    end
    grant = '0;
    if (|req) grant[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  ptr <= '0;
    else if (en) ptr <= winner + 1'b1;
  end

endmodule

// File: rtl/mcore_imem_net_arbiter.sv
// Merges per-core imem requests into one tagged memory stream and steers responses back by source ID.
module mcore_imem_net_arbiter
  import mcore_imem_net_arbiter_pkg::*;
#(
  parameter int p_num_ports  = 4,
  parameter int p_req_qdepth = 2
) (
  input logic                   clk,
  input logic                   reset,
  mcore_imem_net_arbiter_if.slave bus
);

  localparam int c_id_w = $clog2(p_num_ports);
  localparam int c_pw   = (p_req_qdepth > 1) ? $clog2(p_req_qdepth) : 1;
  localparam int c_cw   = $clog2(p_req_qdepth + 1);

  logic [p_num_ports-1:0] grant;
  logic [c_id_w-1:0]      winner;
  mem_req_16B_t           enq_msg;
  mem_req_16B_t           q [p_req_qdepth];
  logic [c_pw-1:0]        wr_ptr, rd_ptr;
  logic [c_cw-1:0]        cnt;
  logic                   enq, deq, can_enq;

  mcore_rr_arbiter #(.p_n(p_num_ports)) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.in_req_val),
    .en     (enq),
    .grant  (grant),
    .winner (winner)
  );

  // A full queue still accepts when its head leaves this same cycle.
  assign deq            = (cnt != '0) && bus.mem_req_rdy;
  assign can_enq        = (cnt != c_cw'(p_req_qdepth)) || deq;
  assign enq            = (|grant) && can_enq;
  assign bus.in_req_rdy = grant & {p_num_ports{can_enq}};

  always_comb begin
    enq_msg        = bus.in_req_msg[winner];
    enq_msg.opaque = set_src_id(enq_msg.opaque, winner);
  end

  function automatic logic [c_pw-1:0] nxt(input logic [c_pw-1:0] p);
    return (p == c_pw'(p_req_qdepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= nxt(wr_ptr);
      if (deq) rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + c_cw'(enq) - c_cw'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) q[wr_ptr] <= enq_msg;
  end

  assign bus.mem_req_val = (cnt != '0);
  assign bus.mem_req_msg = bus.mem_req_val ? q[rd_ptr] : '0;

  logic                                resp_full, resp_out, resp_rdy;
  mem_resp_16B_t                       resp_q;
  logic [c_id_w-1:0]                   dest;
  logic          [p_num_ports-1:0]     resp_val;
  mem_resp_16B_t [p_num_ports-1:0]     resp_msg;

  assign dest     = resp_q.opaque[c_src_id_msb:c_src_id_lsb];
  assign resp_out = resp_full && bus.in_resp_rdy[dest];
  assign resp_rdy = !resp_full || resp_out;
  assign bus.mem_resp_rdy = resp_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_full <= 1'b0;
      resp_q    <= '0;
    end else if (bus.mem_resp_val && resp_rdy) begin
      resp_full <= 1'b1;
      resp_q    <= bus.mem_resp_msg;
    end else if (resp_out) begin
      resp_full <= 1'b0;
    end
  end

  // Only the destination port sees the message; its ID bits are returned to zero.
  always_comb begin
    resp_val = '0;
    resp_msg = '0;
    for (int i = 0; i < p_num_ports; i++) begin
      resp_val[i] = resp_full && (dest == c_id_w'(i));
      if (resp_val[i]) begin
        resp_msg[i]        = resp_q;
        resp_msg[i].opaque = set_src_id(resp_q.opaque, '0);
      end
    end
  end

  assign bus.in_resp_val = resp_val;
  assign bus.in_resp_msg = resp_msg;

endmodule

// File: tb/tb_mcore_imem_net_arbiter.sv
// Bench for the imem network arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_mcore_imem_net_arbiter;
  import mcore_imem_net_arbiter_pkg::*;

  localparam int D = 2;

  logic clk;
  logic reset;

  mcore_imem_net_arbiter_if #(.p_num_ports(4)) bus ();

  mcore_imem_net_arbiter #(.p_num_ports(4), .p_req_qdepth(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { mem_req_16B_t msg; int core; } ent_t;

  int            n_chk, n_pass;
  ent_t          qm[$];
  ent_t          pend[$];
  int            obs_log[$];
  int            ptr_m, held_core, resp_core, last_acc, delivered;
  bit            held, stress, last_ifire;
  mem_resp_16B_t held_msg;
  logic [7:0]    held_orig, resp_orig;
  mem_req_16B_t  cur[4];

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [1:0] ix(input int i);
    return i[1:0];
  endfunction

  function automatic mem_req_16B_t rnd_req();
    mem_req_16B_t m;
    m.msg_type = 3'($urandom);
    m.opaque   = {2'b00, 6'($urandom)};
    m.addr     = $urandom;
    m.len      = 4'($urandom);
    m.data     = {$urandom, $urandom, $urandom, $urandom};
    return m;
  endfunction

  function automatic mem_resp_16B_t mk_resp(input ent_t e);
    mem_resp_16B_t r;
    r.msg_type = e.msg.msg_type;
    r.opaque   = e.msg.opaque;
    r.test     = 2'($urandom);
    r.len      = e.msg.len;
    r.data     = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  task automatic model_reset();
    qm.delete();
    pend.delete();
    held   = 1'b0;
    ptr_m  = 0;
  endtask

  // One clock: inputs already driven at posedge+1; check outputs, then advance the model.
  task automatic step();
    int            w;
    bit            can, acc, deq, ofire, ifire, mrdy;
    ent_t          ne;
    mem_resp_16B_t em, rm;
    int            rc;
    logic [7:0]    ro;
    #3;
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && bus.in_req_val[ix(ptr_m + k)]) w = (ptr_m + k) % 4;
    can = (qm.size() < D) || (qm.size() > 0 && bus.mem_req_rdy);
    acc = (w >= 0) && can;
    chk("in_req_rdy", bus.in_req_rdy, acc ? 4'(1 << w) : 4'b0);
    chk("mem_req_val", bus.mem_req_val, qm.size() > 0);
    if (qm.size() > 0) chk("mem_req_msg", bus.mem_req_msg, qm[0].msg);
    chk("in_resp_val", bus.in_resp_val, held ? 4'(1 << held_core) : 4'b0);
    if (held) begin
      em = held_msg;
      em.opaque = held_orig;
      chk("in_resp_msg", bus.in_resp_msg[ix(held_core)], em);
    end
    mrdy = !held || bus.in_resp_rdy[ix(held_core)];
    chk("mem_resp_rdy", bus.mem_resp_rdy, mrdy);
    for (int i = 0; i < 4; i++) if (bus.in_req_rdy[ix(i)]) obs_log.push_back(i);
    deq   = qm.size() > 0 && bus.mem_req_rdy;
    ofire = held && bus.in_resp_rdy[ix(held_core)];
    ifire = bus.mem_resp_val && mrdy;
    if (acc) begin
      ne.msg = bus.in_req_msg[ix(w)];
      ne.msg.opaque = {2'(w), ne.msg.opaque[5:0]};
      ne.core = w;
    end
    rm = bus.mem_resp_msg;
    rc = resp_core;
    ro = resp_orig;
    @(posedge clk);
    #1;
    if (deq) pend.push_back(qm.pop_front());
    last_acc = acc ? w : -1;
    if (acc) begin
      qm.push_back(ne);
      ptr_m = (w + 1) % 4;
    end
    if (ofire) begin
      held = 1'b0;
      delivered++;
    end
    last_ifire = ifire;
    if (ifire) begin
      held      = 1'b1;
      held_msg  = rm;
      held_core = rc;
      held_orig = ro;
      if (stress) void'(pend.pop_front());
    end
  endtask

  initial begin
    mem_req_16B_t  m;
    mem_resp_16B_t r, r2;
    int            base, total, base_del, cyc;
    int            share[4];

    n_chk = 0; n_pass = 0; delivered = 0; stress = 0; last_ifire = 0;
    resp_core = 0; resp_orig = '0; held_core = 0;
    model_reset();
    reset = 1'b0;
    bus.in_req_msg = '0; bus.in_req_val = '0; bus.in_resp_rdy = '1;
    bus.mem_req_rdy = 1'b0; bus.mem_resp_msg = '0; bus.mem_resp_val = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req_val", bus.mem_req_val, 1'b0);
    chk("rst_in_resp_val", bus.in_resp_val, 4'b0);
    chk("rst_mem_resp_rdy", bus.mem_resp_rdy, 1'b1);
    reset = 1'b1;

    // All four cores contending: grants rotate 0,1,2,3 from reset.
    for (int c = 0; c < 4; c++) bus.in_req_msg[ix(c)] = rnd_req();
    bus.in_req_val = 4'hF;
    bus.mem_req_rdy = 1'b1;
    base = obs_log.size();
    repeat (12) step();
    for (int k = 0; k < 12; k++) chk("rr_order", 32'(obs_log[base + k]), 32'(k % 4));
    share = '{0, 0, 0, 0};
    for (int k = base; k < obs_log.size(); k++) share[obs_log[k]]++;
    for (int c = 0; c < 4; c++) chk("rr_share", 32'(share[c]), 32'd3);
    bus.in_req_val = '0;
    repeat (2) step();
    pend.delete();

    // Single request from core 2 gets tagged with ID 2 and comes back untagged on port 2.
    m = rnd_req();
    m.addr = 32'h1000;
    m.opaque = 8'h05;
    bus.in_req_msg[2] = m;
    bus.in_req_val = 4'b0100;
    bus.mem_req_rdy = 1'b0;
    step();
    bus.in_req_val = '0;
    chk("tag_val", bus.mem_req_val, 1'b1);
    chk("tag_opaque", bus.mem_req_msg.opaque, 8'h85);
    chk("tag_addr", bus.mem_req_msg.addr, 32'h1000);
    bus.mem_req_rdy = 1'b1;
    step();
    r = '0;
    r.opaque = 8'h85;
    r.data = {$urandom, $urandom, $urandom, $urandom};
    bus.mem_resp_msg = r; bus.mem_resp_val = 1'b1;
    resp_core = 2; resp_orig = 8'h05;
    step();
    bus.mem_resp_val = 1'b0;
    chk("steer_val", bus.in_resp_val, 4'b0100);
    chk("steer_opaque", bus.in_resp_msg[2].opaque, 8'h05);
    chk("steer_data", bus.in_resp_msg[2].data, r.data);
    step();
    pend.delete();

    // Memory stalled: two accepts fill the queue, then it drains in order 0,1.
    bus.in_req_msg[0] = rnd_req(); bus.in_req_msg[1] = rnd_req();
    bus.in_req_val = 4'b0011;
    bus.mem_req_rdy = 1'b0;
    base = obs_log.size();
    repeat (5) step();
    chk("full_accepts", 32'(obs_log.size() - base), 32'd2);
    chk("full_rdy_low", bus.in_req_rdy, 4'b0);
    bus.in_req_val = '0;
    bus.mem_req_rdy = 1'b1;
    chk("drain_first", bus.mem_req_msg.opaque[7:6], 2'd0);
    step();
    chk("drain_second", bus.mem_req_msg.opaque[7:6], 2'd1);
    step();
    chk("drain_empty", bus.mem_req_val, 1'b0);
    pend.delete();

    // Core 3 back-pressure holds the response register; the next response enters as it leaves.
    r = '0; r.opaque = 8'hC3; r.data = {$urandom, $urandom, $urandom, $urandom};
    bus.in_resp_rdy = 4'b0111;
    bus.mem_resp_msg = r; bus.mem_resp_val = 1'b1;
    resp_core = 3; resp_orig = 8'h03;
    step();
    r2 = '0; r2.opaque = 8'h4A; r2.data = {$urandom, $urandom, $urandom, $urandom};
    bus.mem_resp_msg = r2;
    resp_core = 1; resp_orig = 8'h0A;
    repeat (3) begin
      step();
      chk("bp_hold_val", bus.in_resp_val, 4'b1000);
      chk("bp_hold_data", bus.in_resp_msg[3].data, r.data);
      chk("bp_mem_rdy", bus.mem_resp_rdy, 1'b0);
    end
    bus.in_resp_rdy = 4'hF;
    step();
    bus.mem_resp_val = 1'b0;
    chk("bp_second", bus.in_resp_val, 4'b0010);
    chk("bp_second_op", bus.in_resp_msg[1].opaque, 8'h0A);
    step();

    // Async reset with queue and response register both occupied.
    bus.in_req_msg[0] = rnd_req();
    bus.in_req_val = 4'b0001;
    bus.mem_req_rdy = 1'b0;
    repeat (2) step();
    bus.in_req_val = '0;
    r = '0; r.opaque = 8'h01;
    bus.mem_resp_msg = r; bus.mem_resp_val = 1'b1;
    resp_core = 0; resp_orig = 8'h01;
    bus.in_resp_rdy = 4'b0;
    step();
    bus.mem_resp_val = 1'b0;
    chk("pre_rst_req_val", bus.mem_req_val, 1'b1);
    chk("pre_rst_resp_val", bus.in_resp_val, 4'b0001);
    #2 reset = 1'b0;
    #1;
    chk("async_req_val", bus.mem_req_val, 1'b0);
    chk("async_resp_val", bus.in_resp_val, 4'b0);
    chk("async_mem_rdy", bus.mem_resp_rdy, 1'b1);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    bus.in_resp_rdy = 4'hF;
    for (int c = 0; c < 4; c++) bus.in_req_msg[ix(c)] = rnd_req();
    bus.in_req_val = 4'hF;
    bus.mem_req_rdy = 1'b1;
    base = obs_log.size();
    step();
    chk("ptr_after_rst", 32'(obs_log[base]), 32'd0);
    bus.in_req_val = '0;
    repeat (2) step();

    // Random traffic: 1000 requests, random back-pressure on every handshake.
    stress = 1; last_ifire = 0; pend.delete();
    base_del = delivered; total = 0; cyc = 0;
    for (int c = 0; c < 4; c++) cur[c] = rnd_req();
    while (cyc < 30000 && !(total >= 1000 && qm.size() == 0 && pend.size() == 0 &&
                            !held && !bus.mem_resp_val)) begin
      for (int c = 0; c < 4; c++) begin
        bus.in_req_msg[ix(c)] = cur[c];
        bus.in_req_val[ix(c)] = (total < 1000) && ($urandom % 4 != 0);
      end
      bus.mem_req_rdy = (total >= 1000) || ($urandom % 3 != 0);
      bus.in_resp_rdy = (total >= 1000) ? 4'hF : 4'($urandom);
      if (!bus.mem_resp_val || last_ifire) begin
        if (pend.size() > 0 && $urandom % 4 != 0) begin
          bus.mem_resp_msg = mk_resp(pend[0]);
          bus.mem_resp_val = 1'b1;
          resp_core = pend[0].core;
          resp_orig = {2'b00, pend[0].msg.opaque[5:0]};
        end else begin
          bus.mem_resp_val = 1'b0;
        end
      end
      step();
      if (last_acc >= 0) begin
        total++;
        cur[last_acc] = rnd_req();
      end
      cyc++;
    end
    chk("stress_accepted", 32'(total), 32'd1000);
    chk("stress_delivered", 32'(delivered - base_del), 32'd1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mcore_imem_net_arbiter.md
Name: mcore_imem_net_arbiter

Overview:
- Sits directly downstream of the four-core complex, on the instruction-memory side.
- Merges the per-core imemnetreq streams into one request port to the shared memory, using round-robin arbitration and a small output queue.
- Steers each memory response back to the originating core's imemnetresp port, using a source ID carried in the opaque field.
- Supplies the imemnetreq_rdy and imemnetresp_msg/val signals the cores consume.

Parameters:
- p_num_ports, 4: number of requesting cores; must be 4 with a 2-bit source ID.
- p_req_qdepth, 2: entries in the request output queue (≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_req_msg  in  p_num_ports×175  per-core mem_req_16B_t requests.
- in_req_val  in  p_num_ports  per-core request valid.
- in_req_rdy  out  p_num_ports  per-core request ready.
- in_resp_msg  out  p_num_ports×145  per-core mem_resp_16B_t responses.
- in_resp_val  out  p_num_ports  per-core response valid.
- in_resp_rdy  in  p_num_ports  per-core response ready.
- mem_req_msg  out  175  merged request to memory.
- mem_req_val  out  1  merged request valid.
- mem_req_rdy  in  1  memory ready.
- mem_resp_msg  in  145  response from memory.
- mem_resp_val  in  1  memory response valid.
- mem_resp_rdy  out  1  memory response ready.

Behaviour:
- Reset (reset==0, asynchronous) clears the following:
  - round-robin pointer to 0;
  - request queue to empty, so mem_req_val=0;
  - response register to empty, so all in_resp_val=0.
- mem_resp_rdy=1 while in reset.
- Any reset assertion mid-transaction discards all in-flight entries. No partial message ever appears on an output.
- Request arbitration:
  - Combinational one-hot grant among in_req_val, searched starting at the pointer and wrapping 3→0.
  - in_req_rdy[i] = grant[i] & queue-not-full.
  - At most one request is accepted per cycle.
  - On acceptance the pointer moves to (winner+1) mod 4. With no acceptance the pointer holds.
- Opaque tagging:
  - The accepted message is enqueued with opaque[7:6] replaced by the winner index.
  - All other fields are unchanged.
  - Cores must drive opaque[7:6]=0. Nonzero values are overwritten and never restored.
- Request queue:
  - Normal (non-bypass) FIFO of depth p_req_qdepth.
  - Minimum latency is 1 cycle from acceptance to mem_req_val.
  - Same-cycle enqueue and dequeue is allowed when full, so a full queue that is draining accepts a new request.
  - Messages leave in order.
- Response path:
  - 1-entry response register.
  - mem_resp_rdy = register empty OR the register's destination port is firing this cycle (pipelined, no bubble).
  - Destination d = held opaque[7:6].
  - in_resp_val[d]=1 and all other in_resp_val=0.
  - in_resp_msg[d] carries the held message with opaque[7:6] cleared to 0.
  - Message lines of non-selected ports are don't-care; drive them to 0.
  - Latency is 1 cycle from mem_resp fire to in_resp_val.
  - Back-pressure on port d stalls the whole response path. This is accepted; memory responds in order.
- Simultaneous events:
  - Request enqueue and response fire in the same cycle are independent.
  - Queue enqueue and dequeue in the same cycle leave the count unchanged.
- Widths: the ID field is $clog2(p_num_ports)=2 bits. The pointer wraps modulo p_num_ports.

Decomposition:
- Shared mcore package holds:
  - mem_req_16B_t / mem_resp_16B_t (from vc/mem-msgs);
  - the constants c_src_id_msb=7, c_src_id_lsb=6;
  - the function that replaces the opaque ID field.
- One natural sub-module: mcore_rr_arbiter, a parameterised round-robin arbiter (req, en → one-hot grant, pointer state).
- Instantiate the request queue from the vc queue library, with its reset adapted to active-low.

Test Plan:
- Reset, then core 2 alone sends a req with addr 0x1000, opaque 0x05:
  - the next cycle mem_req shows opaque 0x85, addr 0x1000;
  - a response with opaque 0x85 returns on port 2 with opaque 0x05 one cycle after firing.
- All four cores valid every cycle, mem_req_rdy=1: grants go 0,1,2,3,0,1… and each core gets exactly 1 of every 4 acceptances.
- mem_req_rdy=0 for 5 cycles with cores 0 and 1 valid:
  - exactly 2 requests are accepted, then all in_req_rdy=0;
  - when rdy returns, they drain in order 0,1.
- Response to core 3 with in_resp_rdy[3]=0 for 3 cycles:
  - in_resp_val[3] holds with the message stable;
  - mem_resp_rdy=0 while the register is full;
  - a second response is accepted in the same cycle the first fires.
- Reset asserted asynchronously mid-cycle with the queue and response register full: all outputs valid=0 immediately, and the pointer is back to 0 after release.
- Random stress: 1000 requests with random val/rdy back-pressure; a scoreboard checks in-order delivery to memory, correct port steering, and opaque restoration.
